serial_cmd_rx: RTL and testbench

SERIAL_CMD_RX -- requirements
Module: serial_cmd_rx

---
 rtl/serial_cmd_pkg.sv | 28 ++
 rtl/serial_reply_tx.sv | 48 ++++
 rtl/serial_cmd_rx.sv | 111 +++++++++++
 tb/tb_serial_cmd_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmd_pkg.sv
// serial_cmd_pkg: FSM states, ASCII constants and reply tables for the serial LED command receiver.
package serial_cmd_pkg;

    typedef enum logic [2:0] {IDLE, GOT_L, GOT_D, DISCARD, REPLY} state_t;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CH_UL = 8'h4C;
    localparam logic [7:0] CH_LL = 8'h6C;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_7  = 8'h37;
    localparam logic [7:0] CH_O  = 8'h4F;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_R  = 8'h52;

    // Byte 0 of each reply sits in the low lane.
    localparam logic [31:0] OK_REPLY = {LF, CR, CH_K, CH_O};
    localparam logic [31:0] ER_REPLY = {LF, CR, CH_R, CH_E};

    function automatic logic [7:0] reply_byte(input logic ok, input logic [1:0] idx);
        logic [31:0] t;
        t = ok ? OK_REPLY : ER_REPLY;
        return t[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/serial_reply_tx.sv
// serial_reply_tx: streams the selected 4-byte reply onto a valid/ready handshake, pulsing done on the last transfer.
module serial_reply_tx
    import serial_cmd_pkg::*;
(
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       start,
    input  logic       sel_ok,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       done
);

    logic [1:0] idx_q, idx_d;
    logic       sel_q, sel_d;
    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;
    logic       xfer;

    assign xfer     = valid_q & tx_ready;
    assign done     = xfer & (idx_q == 2'd3);
    assign tx_data  = data_q;
    assign tx_valid = valid_q;

    always_comb begin
        idx_d   = start ? 2'd0 : xfer ? idx_q + 2'd1 : idx_q;
        sel_d   = start ? sel_ok : sel_q;
        valid_d = start | (valid_q & ~done);
        data_d  = start ? reply_byte(sel_ok, 2'd0) :
                  (xfer & ~done) ? reply_byte(sel_q, idx_q + 2'd1) : data_q;
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= 2'd0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/serial_cmd_rx.sv
// serial_cmd_rx: parses "L<0-7>\r" commands from a byte stream, drives the LED register and answers OK/ER.
module serial_cmd_rx
    import serial_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 48000000,
    parameter logic [2:0] LED_RESET      = 3'b000
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [2:0] led,
    output logic       cmd_strobe,
    output logic [7:0] err_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t          state_q, state_d;
    logic            rx_ready_q, rx_ready_d;
    logic [2:0]      led_q, led_d;
    logic [2:0]      dig_q, dig_d;
    logic            strobe_q, strobe_d;
    logic [7:0]      err_q, err_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            accept, is_digit, is_cr, start, sel_ok, done;

    assign accept     = rx_valid & rx_ready_q;
    assign is_digit   = (rx_data >= CH_0) && (rx_data <= CH_7);
    assign is_cr      = rx_data == CR;
    assign rx_ready   = rx_ready_q;
    assign led        = led_q;
    assign cmd_strobe = strobe_q;
    assign err_count  = err_q;

    always_comb begin
        state_d  = state_q;
        led_d    = led_q;
        dig_d    = dig_q;
        strobe_d = 1'b0;
        start    = 1'b0;
        sel_ok   = 1'b0;
        tmo_d    = '0;
        case (state_q)
            IDLE: if (accept)
                state_d = (rx_data == CH_UL || rx_data == CH_LL) ? GOT_L :
                          (rx_data == LF || is_cr || rx_data == SPACE) ? IDLE : DISCARD;
            GOT_L: if (accept) begin
                state_d = is_digit ? GOT_D : is_cr ? REPLY : DISCARD;
                dig_d   = is_digit ? rx_data[2:0] : dig_q;
                start   = is_cr;
            end
            GOT_D: if (accept) begin
                state_d  = is_cr ? REPLY : DISCARD;
                led_d    = is_cr ? dig_q : led_q;
                strobe_d = is_cr;
                start    = is_cr;
                sel_ok   = is_cr;
            end
            DISCARD: if (accept) begin
                state_d = is_cr ? REPLY : DISCARD;
                start   = is_cr;
            end
            REPLY: state_d = done ? IDLE : REPLY;
            default: state_d = IDLE;
        endcase
        // An accepted byte wins over an expiring timeout.
        if ((state_q == GOT_L || state_q == GOT_D || state_q == DISCARD) && !accept) begin
            tmo_d   = (tmo_q == TW'(TIMEOUT_CYCLES - 1)) ? '0 : tmo_q + TW'(1);
            state_d = (tmo_q == TW'(TIMEOUT_CYCLES - 1)) ? IDLE : state_d;
        end
        err_d      = (start && !sel_ok && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        rx_ready_d = state_d != REPLY;
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rx_ready_q <= 1'b0;
            led_q      <= LED_RESET;
            dig_q      <= 3'd0;
            strobe_q   <= 1'b0;
            err_q      <= 8'd0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            led_q      <= led_d;
            dig_q      <= dig_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    serial_reply_tx u_reply (
        .clk_48mhz (clk_48mhz),
        .reset_n   (reset_n),
        .start     (start),
        .sel_ok    (sel_ok),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .done      (done)
    );

endmodule

// File: tb/tb_serial_cmd_rx.sv
// tb_serial_cmd_rx: directed scoreboard bench for serial_cmd_rx (short timeout so the drop path is reachable).
module tb_serial_cmd_rx;

    localparam int         TMO = 16;
    localparam logic [2:0] LR  = 3'b000;

    logic       clk_48mhz = 1'b0;
    logic       reset_n   = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       rx_valid  = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready  = 1'b1;
    logic [2:0] led;
    logic       cmd_strobe;
    logic [7:0] err_count;

    int         checks = 0, errors = 0, strobes = 0, tx_count = 0;
    logic [7:0] exp_q[$];
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    serial_cmd_rx #(.TIMEOUT_CYCLES(TMO), .LED_RESET(LR)) dut (
        .clk_48mhz  (clk_48mhz),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .led        (led),
        .cmd_strobe (cmd_strobe),
        .err_count  (err_count)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1, so a handshake seen here is what the next posedge will act on.
    always @(negedge clk_48mhz) begin
        if (reset_n) begin
            if (cmd_strobe) strobes++;
            if (hold_v) begin
                checks++;
                assert (tx_valid === 1'b1 && tx_data === hold_d) else begin
                    errors++;
                    $error("FAIL tx_hold: observed v=%0b d=%0h expected v=1 d=%0h", tx_valid, tx_data, hold_d);
                end
            end
            if (tx_valid && tx_ready) begin
                tx_count++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL tx_unexpected: observed byte %0h expected no transfer", tx_data);
                end
                if (exp_q.size() != 0) chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            hold_v = tx_valid && !tx_ready;
            hold_d = tx_data;
        end else hold_v = 1'b0;
    end

    task automatic send(input logic [7:0] b);
        logic acc;
        int   n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        do begin
            @(negedge clk_48mhz);
            acc = rx_ready;
            @(posedge clk_48mhz);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("rx_accept_timeout", 0, 1);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic push_reply(input bit ok);
        exp_q.push_back(ok ? 8'h4F : 8'h45);
        exp_q.push_back(ok ? 8'h4B : 8'h52);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic drain(input logic [3:0] pat);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_valid) && n < 500) begin
            tx_ready = pat[3 - (n % 4)];
            @(posedge clk_48mhz);
            #1;
            n++;
        end
        tx_ready = 1'b1;
        chk("reply_drain", {31'd0, exp_q.size() == 0 && !tx_valid}, 1);
        @(posedge clk_48mhz);
        #1;
    endtask

    initial begin
        int s0, t0;
        repeat (3) @(posedge clk_48mhz);
        @(negedge clk_48mhz);
        chk("rst_rx_ready", {31'd0, rx_ready}, 0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_led", {29'd0, led}, {29'd0, LR});
        chk("rst_strobe", {31'd0, cmd_strobe}, 0);
        chk("rst_err", {24'd0, err_count}, 0);
        @(posedge clk_48mhz);
        #1 reset_n = 1'b1;
        @(posedge clk_48mhz);
        #1 chk("rx_ready_after_release", {31'd0, rx_ready}, 1);

        s0 = strobes;
        t0 = tx_count;
        push_reply(1);
        send_str("L5\r");
        chk("tx_valid_after_cr", {31'd0, tx_valid}, 1);
        chk("rx_ready_in_reply", {31'd0, rx_ready}, 0);
        drain(4'b1111);
        chk("led_L5", {29'd0, led}, 32'd5);
        chk("strobe_L5", s0 + 1, strobes);
        chk("bytes_L5", tx_count - t0, 4);
        chk("err_L5", {24'd0, err_count}, 0);

        push_reply(0);
        send_str("LX9\r");
        tx_ready = 1'b0;
        rx_data  = 8'h4C;
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_48mhz);
            chk("rx_ready_blocked", {31'd0, rx_ready}, 0);
        end
        @(posedge clk_48mhz);
        #1 rx_valid = 1'b0;
        drain(4'b1111);
        chk("led_LX9", {29'd0, led}, 32'd5);
        chk("err_LX9", {24'd0, err_count}, 1);

        s0 = strobes;
        t0 = tx_count;
        push_reply(1);
        send_str("l3\r");
        drain(4'b1001);
        chk("bytes_l3", tx_count - t0, 4);
        chk("strobe_l3", s0 + 1, strobes);
        chk("led_l3", {29'd0, led}, 32'd3);

        push_reply(0);
        send("L");
        repeat (TMO) @(posedge clk_48mhz);
        #1 send_str("2\r");
        drain(4'b1111);
        chk("err_timeout", {24'd0, err_count}, 2);
        chk("led_timeout", {29'd0, led}, 32'd3);

        for (int i = 0; i < 256; i++) begin
            push_reply(0);
            send_str("Q\r");
            drain(4'b1111);
        end
        chk("err_saturate", {24'd0, err_count}, 255);
        t0 = tx_count;
        send_str("\n\n\r");
        repeat (10) @(posedge clk_48mhz);
        #1 chk("blank_no_reply", tx_count, t0);
        chk("blank_err", {24'd0, err_count}, 255);

        exp_q.push_back(8'h4F);
        exp_q.push_back(8'h4B);
        t0 = tx_count;
        send_str("L6\r");
        for (int n = 0; n < 50 && tx_count != t0 + 2; n++) begin
            @(posedge clk_48mhz);
            #1;
        end
        chk("two_bytes_before_reset", tx_count - t0, 2);
        reset_n = 1'b0;
        #1;
        chk("abort_tx_valid", {31'd0, tx_valid}, 0);
        chk("abort_led", {29'd0, led}, {29'd0, LR});
        chk("abort_err", {24'd0, err_count}, 0);
        repeat (3) @(posedge clk_48mhz);
        #1 reset_n = 1'b1;
        repeat (20) @(posedge clk_48mhz);
        #1 chk("no_tx_after_release", tx_count - t0, 2);
        chk("idle_tx_valid", {31'd0, tx_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
